// File: rtl/instr_sequencer_if.sv
// Sequencer-to-ROM/processor signal bundle; names are from the sequencer's point of view.
interface instr_sequencer_if #(
  parameter int N = 9,
  parameter int A = 5
);
  logic         i_start;
  logic         i_halt;
  logic [N-1:0] i_mem_data;
  logic         i_done;
  logic [A-1:0] o_mem_addr;
  logic [N-1:0] o_din;
  logic         o_run;
  logic         o_busy;
  logic [A-1:0] o_pc;
  logic [7:0]   o_instr_count;
  logic         o_error;

  modport master (
    input  i_start, i_halt, i_mem_data, i_done,
    output o_mem_addr, o_din, o_run, o_busy, o_pc, o_instr_count, o_error
  );

  modport slave (
    output i_start, i_halt, i_mem_data, i_done,
    input  o_mem_addr, o_din, o_run, o_busy, o_pc, o_instr_count, o_error
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetches one- or two-word instructions from a synchronous ROM and issues them to the
// 9-bit multi-cycle processor with a one-cycle Run pulse, then waits for Done.
module instr_sequencer #(
  parameter int N          = 9,
  parameter int A          = 5,
  parameter int START_ADDR = 0,
  parameter int STOP_ADDR  = 2**A - 1,
  parameter int WD_LIMIT   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  instr_sequencer_if.master      bus
);

  localparam int WDW = $clog2(WD_LIMIT + 1);
  localparam logic [A-1:0]   L_START = START_ADDR[A-1:0];
  localparam logic [A-1:0]   L_STOP  = STOP_ADDR[A-1:0];
  localparam logic [WDW-1:0] L_WD_LAST = WDW'(WD_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_LOAD, S_ISSUE, S_EXEC
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_word0;
  logic [N-1:0]   r_word1;
  logic [N-1:0]   r_din;
  logic           r_run;
  logic           r_error;
  logic [A-1:0]   r_pc;
  logic [7:0]     r_icnt;
  logic [WDW-1:0] r_wd;

  logic           w_is_mvi;
  logic [A-1:0]   w_pc_next;

  assign w_is_mvi  = (r_word0[N-1:N-3] == 3'b001);
  assign w_pc_next = r_pc + (w_is_mvi ? A'(2) : A'(1));

  // The immediate is requested during FETCH1 so it arrives in LOAD; wraps past the top of ROM.
  assign bus.o_mem_addr    = (r_state == S_FETCH1) ? r_pc + A'(1) : r_pc;
  assign bus.o_din         = r_din;
  assign bus.o_run         = r_run;
  assign bus.o_busy        = (r_state != S_IDLE);
  assign bus.o_pc          = r_pc;
  assign bus.o_instr_count = r_icnt;
  assign bus.o_error       = r_error;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_word0 <= '0;
      r_word1 <= '0;
      r_din   <= '0;
      r_run   <= 1'b0;
      r_error <= 1'b0;
      r_pc    <= L_START;
      r_icnt  <= '0;
      r_wd    <= '0;
    end else begin
      r_run <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start && !bus.i_halt) begin
            r_error <= 1'b0;
            r_state <= S_FETCH0;
          end
        end
        S_FETCH0: r_state <= S_FETCH1;
        S_FETCH1: begin
          r_word0 <= bus.i_mem_data;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_word1 <= bus.i_mem_data;
          r_din   <= r_word0;
          r_run   <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          // Processor latches IR now; its first execute step already sees the immediate.
          r_din   <= r_word1;
          r_wd    <= '0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (bus.i_done) begin
            r_pc    <= w_pc_next;
            r_icnt  <= r_icnt + 8'd1;
            r_state <= (bus.i_halt || (w_pc_next == L_STOP)) ? S_IDLE : S_FETCH0;
          end else if (r_wd == L_WD_LAST) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: ROM model and Done responder around one sequencer with STOP_ADDR=1.
module tb_instr_sequencer;
  localparam int N = 9;
  localparam int A = 5;
  localparam logic [N-1:0] MV  = 9'b000001000;
  localparam logic [N-1:0] MVI = 9'b001010000;
  localparam logic [N-1:0] ADD = 9'b010000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if #(.N(N), .A(A)) bus ();

  instr_sequencer #(
    .N(N), .A(A), .START_ADDR(0), .STOP_ADDR(1), .WD_LIMIT(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  logic [N-1:0] rom [0:31];
  always @(posedge clk) bus.i_mem_data <= rom[bus.o_mem_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int done_at = 0;

  // Processor stand-in: raises Done in EXEC cycle done_at (0 = never) and records what it saw.
  int cyc = 0, runs = 0, ec = 0, last_ec = 0, last_done_cyc = 0, gap = 0;
  bit in_exec = 0;
  logic [N-1:0] issue_din_first, exec1_din_first, exec1_din_last;

  always @(negedge clk) begin
    cyc++;
    bus.i_done = 1'b0;
    if (rst) begin
      runs = 0; in_exec = 0; ec = 0; last_ec = 0; gap = 0; last_done_cyc = 0;
    end else if (bus.o_run) begin
      runs++;
      if (runs == 1) issue_din_first = bus.o_din;
      else gap = cyc - last_done_cyc;
      in_exec = 1; ec = 0;
    end else if (in_exec) begin
      if (!bus.o_busy) begin
        in_exec = 0; last_ec = ec;
      end else begin
        ec++;
        if (ec == 1) begin
          exec1_din_last = bus.o_din;
          if (runs == 1) exec1_din_first = bus.o_din;
        end
        if (ec == done_at) begin
          bus.i_done = 1'b1; in_exec = 0; last_ec = ec; last_done_cyc = cyc;
        end
      end
    end
  end

  typedef struct {
    logic [N-1:0] w0, w1;
    int done_at;
    bit halt;
    int exp_runs;
    logic [N-1:0] exp_issue, exp_exec1;
    int exp_pc, exp_cnt, exp_err, exp_ec;
  } vec_t;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 32; i++) rom[i] = MV;
  endtask

  task automatic pulse_start(bit halt_after);
    bus.i_start = 1'b1; bus.i_halt = 1'b0;
    tick();
    bus.i_start = 1'b0; bus.i_halt = halt_after;
  endtask

  task automatic wait_idle(int lim, string name);
    int k = 0;
    do begin tick(); k++; end while (bus.o_busy && k < lim);
    check({name, "_idle_timeout"}, int'(bus.o_busy), 0);
  endtask

  task automatic wait_runs(int target, int lim, string name);
    int k = 0;
    while (runs < target && k < lim) begin tick(); k++; end
    check({name, "_run_timeout"}, int'(runs >= target), 1);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{MV,  9'h0AA, 1, 1'b0, 1, MV,  9'h0AA, 1, 1, 0, 1};
    vecs[1] = '{MVI, 9'd5,   1, 1'b1, 1, MVI, 9'd5,   2, 1, 0, 1};
    vecs[2] = '{ADD, 9'h033, 3, 1'b0, 1, ADD, 9'h033, 1, 1, 0, 3};
    vecs[3] = '{ADD, 9'h1FF, 0, 1'b0, 1, ADD, 9'h1FF, 0, 0, 1, 8};
    vecs[4] = '{MV,  9'h100, 8, 1'b0, 1, MV,  9'h100, 1, 1, 0, 8};
    vecs[5] = '{MVI, 9'h1C3, 4, 1'b1, 1, MVI, 9'h1C3, 2, 1, 0, 4};

    bus.i_start = 1'b0;
    bus.i_halt  = 1'b0;
    fill_rom();
    repeat (2) tick();
    check("rst_pc",   int'(bus.o_pc), 0);
    check("rst_cnt",  int'(bus.o_instr_count), 0);
    check("rst_err",  int'(bus.o_error), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_run",  int'(bus.o_run), 0);
    check("rst_din",  int'(bus.o_din), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_reset();
      fill_rom();
      rom[0] = vecs[i].w0;
      rom[1] = vecs[i].w1;
      done_at = vecs[i].done_at;
      pulse_start(vecs[i].halt);
      wait_idle(100, $sformatf("v%0d", i));
      bus.i_halt = 1'b0;
      check($sformatf("v%0d_runs", i),  runs, vecs[i].exp_runs);
      check($sformatf("v%0d_issue", i), int'(issue_din_first), int'(vecs[i].exp_issue));
      check($sformatf("v%0d_exec1", i), int'(exec1_din_first), int'(vecs[i].exp_exec1));
      check($sformatf("v%0d_pc", i),    int'(bus.o_pc), vecs[i].exp_pc);
      check($sformatf("v%0d_cnt", i),   int'(bus.o_instr_count), vecs[i].exp_cnt);
      check($sformatf("v%0d_err", i),   int'(bus.o_error), vecs[i].exp_err);
      check($sformatf("v%0d_exec_cycles", i), last_ec, vecs[i].exp_ec);
    end

    // Halt raised in EXEC of address 4; also Start+Halt together in IDLE.
    do_reset();
    fill_rom();
    rom[0] = MVI; rom[1] = 9'd5; rom[2] = ADD;
    done_at = 3;
    pulse_start(1'b0);
    wait_runs(4, 100, "halt");
    tick();
    bus.i_halt = 1'b1;
    wait_idle(50, "halt");
    check("halt_pc",  int'(bus.o_pc), 5);
    check("halt_cnt", int'(bus.o_instr_count), 4);
    check("halt_gap", gap, 4);
    check("halt_ec",  last_ec, 3);
    repeat (10) tick();
    check("halt_no_more_run", runs, 4);
    bus.i_start = 1'b1;
    repeat (3) tick();
    check("start_and_halt_idle", int'(bus.o_busy), 0);
    bus.i_start = 1'b0; bus.i_halt = 1'b0;

    // Watchdog error, then a new Start clears it.
    do_reset();
    fill_rom();
    rom[0] = ADD;
    done_at = 0;
    pulse_start(1'b0);
    wait_idle(50, "wd");
    check("wd_err", int'(bus.o_error), 1);
    check("wd_pc",  int'(bus.o_pc), 0);
    check("wd_cnt", int'(bus.o_instr_count), 0);
    done_at = 1;
    pulse_start(1'b0);
    check("wd_clear_err",  int'(bus.o_error), 0);
    check("wd_clear_busy", int'(bus.o_busy), 1);
    wait_idle(50, "wd2");
    check("wd2_pc",  int'(bus.o_pc), 1);
    check("wd2_cnt", int'(bus.o_instr_count), 1);

    // Asynchronous reset during FETCH1, then during ISSUE.
    pulse_start(1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("arst_f1_pc",   int'(bus.o_pc), 0);
    check("arst_f1_cnt",  int'(bus.o_instr_count), 0);
    check("arst_f1_busy", int'(bus.o_busy), 0);
    tick();
    rst = 1'b0;
    pulse_start(1'b0);
    wait_runs(1, 20, "arst_issue");
    check("arst_issue_run_pre", int'(bus.o_run), 1);
    rst = 1'b1;
    #1;
    check("arst_issue_run", int'(bus.o_run), 0);
    check("arst_issue_din", int'(bus.o_din), 0);
    tick();
    rst = 1'b0;

    // Walk PC up to 31 and run an mvi there; its immediate comes from address 0.
    do_reset();
    fill_rom();
    rom[0] = MVI; rom[1] = 9'd5; rom[31] = MVI;
    done_at = 1;
    pulse_start(1'b0);
    wait_runs(2, 50, "wrap");
    rom[0] = 9'd7;
    wait_idle(400, "wrap");
    check("wrap_pc",    int'(bus.o_pc), 1);
    check("wrap_cnt",   int'(bus.o_instr_count), 31);
    check("wrap_imm",   int'(exec1_din_last), 7);
    check("wrap_err",   int'(bus.o_error), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
